cr_cp0_randclk_gen: RTL and testbench

//  Parametrised random clock-modulation enable generator for CP0.

---
 rtl/cr_cp0_randclk_gen.sv | 136 +++++++++++++
 tb/tb_cr_cp0_randclk_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_cp0_randclk_gen.sv
// Purpose : pseudo-random clock-modulation enables that force gated-clock enables on for CP0 regions.
// Latency : lfsr value sampled in a RUN cycle appears on randclk_mod_en one cycle later.
// Backpr. : none; free-running source, seed writes outside IDLE are dropped silently.
//
// Ports:
//   forever_cpuclk        ungated CPU clock
//   cpurst_b              synchronous active-low reset
//   cp0_randclk_en        run request (level); dropping it drains in-flight pulses
//   cp0_randclk_seed_vld  seed write strobe, honoured only in IDLE
//   cp0_randclk_seed      seed value; zero selects SEED so the LFSR never locks up
//   cp0_randclk_density   per-channel fire threshold, nibble < density fires
//   cp0_randclk_ch_mask   per-channel fire allow
//   cp0_randclk_hold      extra cycles a fired pulse is held (pulse = hold+1 cycles)
//   randclk_mod_en        registered mod-enable per channel
//   randclk_busy          high whenever the FSM is not IDLE
//
// LFSR_W must be at least 4*CH_NUM so every channel owns a distinct nibble.
module cr_cp0_randclk_gen #(
    parameter int                CH_NUM = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                HOLD_W = 4
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cp0_randclk_en,
    input  logic              cp0_randclk_seed_vld,
    input  logic [LFSR_W-1:0] cp0_randclk_seed,
    input  logic [3:0]        cp0_randclk_density,
    input  logic [CH_NUM-1:0] cp0_randclk_ch_mask,
    input  logic [HOLD_W-1:0] cp0_randclk_hold,
    output logic [CH_NUM-1:0] randclk_mod_en,
    output logic              randclk_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t                         state_q,  state_d;
    logic [LFSR_W-1:0]              lfsr_q,   lfsr_d;
    logic [CH_NUM-1:0][HOLD_W-1:0]  cnt_q,    cnt_d;
    logic [CH_NUM-1:0]              mod_en_q, mod_en_d;
    logic                           busy_q,   busy_d;

    logic [CH_NUM-1:0]              fire;
    logic [3:0]                     nib;
    logic                           cnt_zero;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        mod_en_d = '0;
        fire     = '0;
        nib      = '0;
        cnt_zero = (cnt_q == '0);

        // A channel may only fire from RUN and only once its previous pulse
        // has fully expired, so in-flight pulses are never truncated or
        // re-armed by changes to hold/density/mask.
        for (int i = 0; i < CH_NUM; i++) begin
            nib     = lfsr_q[4*i +: 4];
            fire[i] = (state_q == ST_RUN) && cp0_randclk_ch_mask[i] &&
                      (nib < cp0_randclk_density) && (cnt_q[i] == '0);
            if (fire[i]) begin
                mod_en_d[i] = 1'b1;
                cnt_d[i]    = cp0_randclk_hold;
            end else if (cnt_q[i] != '0) begin
                mod_en_d[i] = 1'b1;
                cnt_d[i]    = cnt_q[i] - CNT_ONE;
            end else begin
                mod_en_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Seed load and run start may share one edge; the first RUN
                // cycle then samples the freshly loaded seed.
                if (cp0_randclk_seed_vld) begin
                    lfsr_d = (cp0_randclk_seed == '0) ? SEED : cp0_randclk_seed;
                end
                if (cp0_randclk_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & POLY)};
                if (!cp0_randclk_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // With every counter at zero nothing is held this cycle, so
                // mod_en_d is already all zero as IDLE is entered.
                if (cp0_randclk_en) begin
                    state_d = ST_RUN;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            mod_en_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            mod_en_q <= mod_en_d;
            busy_q   <= busy_d;
        end
    end

    assign randclk_mod_en = mod_en_q;
    assign randclk_busy   = busy_q;

endmodule

// File: tb/tb_cr_cp0_randclk_gen.sv
// Purpose : directed plus randomised stimulus for cr_cp0_randclk_gen with a cycle scoreboard.
// Latency : expected outputs are queued before each edge and popped one edge later.
// Backpr. : not applicable; the design has no backpressure.
module tb_cr_cp0_randclk_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        en;
    logic        seed_vld;
    logic [15:0] seed;
    logic [3:0]  density;
    logic [3:0]  mask;
    logic [3:0]  hold;
    logic [3:0]  mod_en;
    logic        busy;

    cr_cp0_randclk_gen dut (
        .forever_cpuclk       (clk),
        .cpurst_b             (rst_b),
        .cp0_randclk_en       (en),
        .cp0_randclk_seed_vld (seed_vld),
        .cp0_randclk_seed     (seed),
        .cp0_randclk_density  (density),
        .cp0_randclk_ch_mask  (mask),
        .cp0_randclk_hold     (hold),
        .randclk_mod_en       (mod_en),
        .randclk_busy         (busy)
    );

    typedef struct packed {
        logic [3:0]  mod_en;
        logic        busy;
        logic [15:0] lfsr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_asserts = 0;
    int          n_fails   = 0;

    // Reference model state: 0 idle, 1 run, 2 drain.
    int          m_state = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    int          m_cnt[4] = '{0, 0, 0, 0};
    logic [3:0]  m_mod   = 4'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Predict the state after the coming edge from the inputs now applied.
    task automatic model_eval();
        int          n_state;
        logic [15:0] n_lfsr;
        int          n_cnt[4];
        logic [3:0]  n_mod;
        logic [3:0]  nib;
        bit          all_zero;
        exp_t        e;
        if (!rst_b) begin
            m_state = 0;
            m_lfsr  = 16'hACE1;
            m_cnt   = '{0, 0, 0, 0};
            m_mod   = 4'b0;
        end else begin
            n_state  = m_state;
            n_lfsr   = m_lfsr;
            n_mod    = 4'b0;
            all_zero = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (m_cnt[c] != 0) all_zero = 1'b0;
            end
            for (int c = 0; c < 4; c++) begin
                nib      = m_lfsr[4*c +: 4];
                n_cnt[c] = 0;
                if (m_state == 1 && mask[c] && nib < density && m_cnt[c] == 0) begin
                    n_mod[c] = 1'b1;
                    n_cnt[c] = int'(hold);
                end else if (m_cnt[c] > 0) begin
                    n_mod[c] = 1'b1;
                    n_cnt[c] = m_cnt[c] - 1;
                end
            end
            case (m_state)
                0: begin
                    if (seed_vld) n_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
                    if (en) n_state = 1;
                end
                1: begin
                    n_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                    if (!en) n_state = 2;
                end
                default: begin
                    if (en) n_state = 1;
                    else if (all_zero) n_state = 0;
                end
            endcase
            m_state = n_state;
            m_lfsr  = n_lfsr;
            m_cnt   = n_cnt;
            m_mod   = n_mod;
        end
        e.mod_en = m_mod;
        e.busy   = (m_state != 0);
        e.lfsr   = m_lfsr;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_eval();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_mod_en", 32'(mod_en), 32'(e.mod_en));
        chk("sb_busy",   32'(busy),   32'(e.busy));
        chk("sb_lfsr",   32'(dut.lfsr_q), 32'(e.lfsr));
    endtask

    task automatic go_idle();
        en       = 1'b0;
        seed_vld = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            tick();
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    logic [3:0] seen_mod;
    int         not_busy;

    initial begin
        rst_b    = 1'b0;
        en       = 1'b1;
        seed_vld = 1'b0;
        seed     = 16'h0;
        density  = 4'd0;
        mask     = 4'h0;
        hold     = 4'd0;

        // Reset held two clocks with run requested.
        tick();
        tick();
        chk("rst_mod_en", 32'(mod_en), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_lfsr",   32'(dut.lfsr_q), 32'hACE1);
        rst_b = 1'b1;
        en    = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Density 2: only channel 0 (nibble 1) fires from ACE1.
        density = 4'd2;
        mask    = 4'hF;
        hold    = 4'd0;
        en      = 1'b1;
        tick();
        chk("t2_run_busy", 32'(busy), 32'd1);
        chk("t2_run_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        chk("t2_c1_mod",   32'(mod_en), 32'd0);
        tick();
        chk("t2_c2_mod",   32'(mod_en), 32'b0001);
        chk("t2_c2_lfsr",  32'(dut.lfsr_q), 32'h59C3);
        tick();
        chk("t2_c3_mod",   32'(mod_en), 32'd0);
        go_idle();

        // Zero seed, seed together with run start, seed during RUN.
        seed_vld = 1'b1;
        seed     = 16'h0;
        tick();
        chk("t4_zero_seed", 32'(dut.lfsr_q), 32'hACE1);
        seed = 16'hBEEF;
        en   = 1'b1;
        tick();
        chk("t4_seed_run_lfsr", 32'(dut.lfsr_q), 32'hBEEF);
        chk("t4_seed_run_busy", 32'(busy), 32'd1);
        seed = 16'h1234;
        tick();
        chk("t4_run_seed_ignored", 32'(dut.lfsr_q), 32'h7DDE);
        go_idle();

        // Hold 3 pulse on channel 0, run dropped in the pulse's 2nd cycle.
        seed_vld = 1'b1;
        seed     = 16'hACE1;
        density  = 4'd15;
        mask     = 4'b0001;
        hold     = 4'd3;
        tick();
        seed_vld = 1'b0;
        en       = 1'b1;
        tick();
        tick();
        chk("t3_p1_mod", 32'(mod_en), 32'b0001);
        tick();
        chk("t3_p2_mod", 32'(mod_en), 32'b0001);
        en = 1'b0;
        tick();
        chk("t3_p3_mod",  32'(mod_en), 32'b0001);
        chk("t3_p3_busy", 32'(busy),   32'd1);
        chk("t3_p3_lfsr", 32'(dut.lfsr_q), 32'h670F);
        tick();
        chk("t3_p4_mod",  32'(mod_en), 32'b0001);
        chk("t3_p4_busy", 32'(busy),   32'd1);
        tick();
        chk("t3_end_mod",  32'(mod_en), 32'd0);
        chk("t3_end_busy", 32'(busy),   32'd0);
        chk("t3_end_lfsr", 32'(dut.lfsr_q), 32'h670F);

        // Suppression: density 0, then mask 0.
        density  = 4'd0;
        mask     = 4'hF;
        en       = 1'b1;
        seen_mod = 4'b0;
        not_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                density = 4'd15;
                mask    = 4'h0;
            end
            tick();
            seen_mod = seen_mod | mod_en;
            if (!busy) not_busy++;
        end
        chk("t5_no_fire",  32'(seen_mod), 32'd0);
        chk("t5_busy_all", 32'(not_busy), 32'd0);
        go_idle();

        // Reset in the middle of a hold-7 pulse.
        seed_vld = 1'b1;
        seed     = 16'hACE1;
        density  = 4'd15;
        mask     = 4'b0001;
        hold     = 4'd7;
        tick();
        seed_vld = 1'b0;
        en       = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t6_cnt_before", 32'(dut.cnt_q[0]), 32'd5);
        chk("t6_mod_before", 32'(mod_en), 32'b0001);
        rst_b = 1'b0;
        tick();
        chk("t6_rst_mod",  32'(mod_en), 32'd0);
        chk("t6_rst_busy", 32'(busy),   32'd0);
        chk("t6_rst_cnt",  32'(dut.cnt_q), 32'd0);
        chk("t6_rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        rst_b = 1'b1;
        en    = 1'b0;
        tick();

        // Randomised traffic: on/off run windows, mid-pulse config changes, seeds, rare resets.
        for (int i = 0; i < 400; i++) begin
            en       = ((i % 60) < 45) ? ($urandom_range(0, 15) != 0) : 1'b0;
            density  = 4'($urandom_range(0, 15));
            mask     = 4'($urandom_range(0, 15));
            hold     = 4'($urandom_range(0, 6));
            seed_vld = ($urandom_range(0, 7) == 0);
            seed     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            rst_b    = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_b = 1'b1;
        go_idle();
        chk("final_mod_idle", 32'(mod_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
